// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor.
package pll_ctrl_pkg;

   localparam int STATE_W    = 3;
   localparam int LOSS_CNT_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_FILTER    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   // Counter width for a terminal count n; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pll_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into a clock domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_ctrl.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, retries on timeout and
// reports a sticky failure once the retry budget is spent.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_FILTER  = 64,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int MAX_RETRIES  = 3
) (
   input  logic                  clkin1,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  pll_lock,
   output logic                  pll_rst,
   output logic                  sys_rst,
   output logic                  locked,
   output logic                  fail,
   output logic [LOSS_CNT_W-1:0] loss_cnt,
   output logic [STATE_W-1:0]    state
);

   localparam int RC_W = cnt_w(RST_CYCLES);
   localparam int FC_W = cnt_w(LOCK_FILTER);
   localparam int TC_W = cnt_w(LOCK_TIMEOUT);
   localparam int RT_W = cnt_w(MAX_RETRIES);

   localparam logic [RC_W-1:0]       RC_LAST  = RC_W'(RST_CYCLES - 1);
   localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(LOCK_FILTER - 1);
   localparam logic [TC_W-1:0]       TC_LAST  = TC_W'(LOCK_TIMEOUT - 1);
   localparam logic [RT_W:0]         RT_MAX   = (RT_W+1)'(MAX_RETRIES);
   localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

   state_e                  state_q, state_d;
   logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;
   logic [FC_W-1:0]         filt_cnt_q, filt_cnt_d;
   logic [TC_W-1:0]         to_cnt_q, to_cnt_d;
   logic [RT_W-1:0]         retry_q, retry_d;
   logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
   logic                    pll_rst_q, sys_rst_q, locked_q, fail_q;
   logic                    lock_s;
   logic                    in_try_q, in_try_d;
   logic                    timeout;
   logic [RT_W:0]           retry_inc;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk_i (clkin1),
      .rst_i (rst),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

   assign in_try_q  = (state_q == ST_WAIT_LOCK) || (state_q == ST_FILTER);
   assign in_try_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_FILTER);
   assign timeout   = in_try_q && (to_cnt_q == TC_LAST);
   assign retry_inc = {1'b0, retry_q} + (RT_W+1)'(1);

   // Next state: restart beats everything, then timeout beats lock progress.
   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = ST_RESET;
      end else begin
         case (state_q)
            ST_RESET:     if (rst_cnt_q == RC_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK,
            ST_FILTER: begin
               if (timeout)                      state_d = (retry_inc == RT_MAX) ? ST_FAIL : ST_RESET;
               else if (!lock_s)                 state_d = ST_WAIT_LOCK;
               else if (state_q == ST_WAIT_LOCK) state_d = ST_FILTER;
               else if (filt_cnt_q == FC_LAST)   state_d = ST_RUN;
            end
            ST_RUN:       if (!lock_s) state_d = ST_RESET;
            ST_FAIL:      state_d = ST_FAIL;
            default:      state_d = ST_RESET;
         endcase
      end
   end

   always_comb begin
      rst_cnt_d  = '0;
      filt_cnt_d = '0;
      to_cnt_d   = '0;
      retry_d    = retry_q;
      loss_d     = loss_q;

      if (state_q == ST_RESET && state_d == ST_RESET && !restart)
         rst_cnt_d = (rst_cnt_q == RC_LAST) ? rst_cnt_q : rst_cnt_q + RC_W'(1);
      if (state_q == ST_FILTER && state_d == ST_FILTER)
         filt_cnt_d = (filt_cnt_q == FC_LAST) ? filt_cnt_q : filt_cnt_q + FC_W'(1);
      if (in_try_q && in_try_d)
         to_cnt_d = (to_cnt_q == TC_LAST) ? to_cnt_q : to_cnt_q + TC_W'(1);

      if (restart)
         retry_d = '0;
      else if (timeout && retry_inc != RT_MAX)
         retry_d = retry_inc[RT_W-1:0];
      else if (state_d == ST_RUN && state_q != ST_RUN)
         retry_d = '0;

      // A lock loss in RUN is counted even when restart claims the transition.
      if (state_q == ST_RUN && !lock_s && loss_q != LOSS_MAX)
         loss_d = loss_q + LOSS_CNT_W'(1);
   end

   always_ff @(posedge clkin1 or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RESET;
         rst_cnt_q  <= '0;
         filt_cnt_q <= '0;
         to_cnt_q   <= '0;
         retry_q    <= '0;
         loss_q     <= '0;
         pll_rst_q  <= 1'b1;
         sys_rst_q  <= 1'b1;
         locked_q   <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         filt_cnt_q <= filt_cnt_d;
         to_cnt_q   <= to_cnt_d;
         retry_q    <= retry_d;
         loss_q     <= loss_d;
         pll_rst_q  <= (state_d == ST_RESET) || (state_d == ST_FAIL);
         sys_rst_q  <= (state_d != ST_RUN);
         locked_q   <= (state_d == ST_RUN);
         fail_q     <= (state_d == ST_FAIL);
      end
   end

   assign pll_rst  = pll_rst_q;
   assign sys_rst  = sys_rst_q;
   assign locked   = locked_q;
   assign fail     = fail_q;
   assign loss_cnt = loss_q;
   assign state    = state_q;

endmodule
